// File: rtl/latch_write_scheduler_pkg.sv
// latch_sched_pkg: shared state encoding, parameter defaults and sizing helper
// for the latch write scheduler.
package latch_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETUP  = 3'd2,
    ENABLE = 3'd3,
    HOLD   = 3'd4
  } state_e;

  // Plain constants of the enum values so legacy code can keep a logic [2:0] state.
  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_CLEAR  = CLEAR;
  localparam logic [2:0] ST_SETUP  = SETUP;
  localparam logic [2:0] ST_ENABLE = ENABLE;
  localparam logic [2:0] ST_HOLD   = HOLD;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_EN_CYC    = 2;

  // Phase counter width: enough bits to hold the longer of the two phases.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/latch_write_scheduler_if.sv
// Requester-side bus of the latch write scheduler: requests, write data,
// clear request and the grant/completion responses.
interface latch_write_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic               clr_req;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               clr_done;
  logic               busy;

  modport master (
    output req, wdata, clr_req,
    input  gnt, done, clr_done, busy
  );

  modport slave (
    input  req, wdata, clr_req,
    output gnt, done, clr_done, busy
  );
endinterface

// File: rtl/latch_write_scheduler_arbiter.sv
// latch_req_arbiter: combinational one-hot pick from the request vector.
// With LATCH_SCHED_RR_EN defined the search is round-robin starting after the
// last winner and the pointer register lives here; otherwise lowest index wins.
module latch_req_arbiter
  import latch_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
`ifdef LATCH_SCHED_RR_EN
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   take,
`endif
  input  logic [NREQ-1:0]                        req,
  output logic [NREQ-1:0]                        pick,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] pick_idx
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic found;

`ifdef LATCH_SCHED_RR_EN
  logic [IW-1:0] ptr;
  int unsigned   j;

  // Rotating search: first requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  // Pointer moves to the slot after the winner on every grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
    end
  end
`else
  // Fixed priority: lowest set request bit wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        pick[k]  = 1'b1;
        pick_idx = IW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/latch_write_scheduler.sv
// latch_write_scheduler: arbitrates NREQ requesters onto a shared level-sensitive
// latch and sequences its d/en/clear pins with setup, enable-width and hold
// phases. Every output is a flop. Define LATCH_SCHED_RR_EN for round-robin
// arbitration; the default build uses fixed lowest-index priority.
module latch_write_scheduler
  import latch_sched_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  latch_write_scheduler_if.slave  bus,
  output logic [DW-1:0]           lat_d,
  output logic                    lat_en,
  output logic                    lat_rst
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = cnt_width(SETUP_CYC, EN_CYC);

  logic [2:0]      state;
  logic [2:0]      next_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_load;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] done_nxt;
  logic            grant;

  assign grant = (state == ST_IDLE) && !bus.clr_req && (|bus.req);

  latch_req_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
`ifdef LATCH_SCHED_RR_EN
    .clk      (clk),
    .rst      (rst),
    .take     (grant),
`endif
    .req      (bus.req),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Next state: clear beats write in IDLE; timed phases leave when the counter reaches 1.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.clr_req)   next_state = ST_CLEAR;
        else if (|bus.req) next_state = ST_SETUP;
      end
      ST_CLEAR:  next_state = ST_IDLE;
      ST_SETUP:  if (cnt == CW'(1)) next_state = ST_ENABLE;
      ST_ENABLE: if (cnt == CW'(1)) next_state = ST_HOLD;
      ST_HOLD:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Phase length loaded on entry to each state; single-cycle states load 1.
  always_comb begin
    cnt_load = CW'(1);
    if (next_state == ST_SETUP)  cnt_load = CW'(SETUP_CYC);
    if (next_state == ST_ENABLE) cnt_load = CW'(EN_CYC);
  end

  // Completion pulse goes to the stored winner as the FSM enters HOLD.
  always_comb begin
    done_nxt = '0;
    if (next_state == ST_HOLD) done_nxt[win_idx] = 1'b1;
  end

  // State register and phase counter; the counter saturates at 1 and never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= CW'(1);
    end else begin
      state <= next_state;
      if (next_state != state)  cnt <= cnt_load;
      else if (cnt > CW'(1))    cnt <= cnt - CW'(1);
    end
  end

  // Grant capture: winner, its data and one-hot grant; grant released leaving HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.gnt <= '0;
      lat_d   <= '0;
      win_idx <= '0;
    end else if (grant) begin
      bus.gnt <= pick;
      lat_d   <= bus.wdata[int'(pick_idx)*DW +: DW];
      win_idx <= pick_idx;
    end else if (state == ST_HOLD) begin
      bus.gnt <= '0;
    end
  end

  // Latch pins and status flops decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_en       <= 1'b0;
      lat_rst      <= 1'b0;
      bus.done     <= '0;
      bus.clr_done <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      lat_en       <= (next_state == ST_ENABLE);
      lat_rst      <= (next_state != ST_CLEAR);
      bus.done     <= done_nxt;
      bus.clr_done <= (next_state == ST_CLEAR);
      bus.busy     <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: doc/latch_write_scheduler.md
# latch_write_scheduler

Sequencing and arbitration controller for a shared level-sensitive D-latch register (data, enable, active-low clear). Up to NREQ requesters compete for write access. The block grants one requester at a time and drives the latch d/en/rst pins with guaranteed setup, enable-width and hold windows. Latch timing is therefore produced by a synchronous FSM rather than by glue logic. A clear request reinitialises the latch through its active-low reset pin.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, latch data width
- SETUP_CYC, 1, cycles lat_d is stable before lat_en rises (>=1)
- EN_CYC, 2, cycles lat_en is held high (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  write requests, level; bit i belongs to requester i
- wdata  in  NREQ*DW  write data; requester i occupies bits [i*DW +: DW]
- clr_req  in  1  latch clear request, level
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- done  out  NREQ  one-cycle completion pulse to the granted requester
- clr_done  out  1  one-cycle pulse when the clear completes
- busy  out  1  high whenever the FSM is not IDLE
- lat_d  out  DW  latch data pin
- lat_en  out  1  latch enable pin
- lat_rst  out  1  latch active-low clear pin

## Operation
- FSM states and transitions:
  - IDLE → CLEAR, if clr_req is high.
  - IDLE → SETUP, if clr_req is low and any req is high.
  - CLEAR → IDLE, after 1 cycle.
  - SETUP → ENABLE, after SETUP_CYC cycles.
  - ENABLE → HOLD, after EN_CYC cycles.
  - HOLD → IDLE, after 1 cycle.
- Arbitration runs only in IDLE. clr_req always beats req.
- On grant:
  - gnt is set one-hot.
  - wdata of the winner is registered into lat_d.
  - The winner index is stored.
- lat_d holds its value from grant until the next grant. It is unchanged in IDLE and CLEAR.
- lat_en is high only in ENABLE.
- lat_rst is low only in CLEAR. In CLEAR, lat_en is 0.
- done[winner] pulses in HOLD. gnt clears on the HOLD→IDLE transition.
- A req dropped mid-transaction has no effect; the transaction completes and done still pulses.
- wdata changes after grant are ignored, because lat_d is registered.
- clr_req asserted during a transaction is deferred to the next IDLE.
- Phase counter:
  - Width is $clog2(max(SETUP_CYC,EN_CYC))+1.
  - Loads at each state entry and counts down to 1.
  - Must not wrap.
- Reset values, applied asynchronously the moment rst goes low:
  - state = IDLE
  - gnt = 0, done = 0, clr_done = 0, busy = 0
  - lat_d = 0, lat_en = 0
  - lat_rst = 0 while rst is low, 1 after release
  - round-robin pointer = 0
- Reset mid-ENABLE drops lat_en at once. That transaction is lost and no done pulse is issued.

## Timing
- Requests are sampled in IDLE at cycle t. gnt and busy are high from t+1.
- lat_en is high from t+1+SETUP_CYC through t+SETUP_CYC+EN_CYC.
- HOLD and the done pulse occur at cycle t+1+SETUP_CYC+EN_CYC.
- The FSM is back in IDLE at t+2+SETUP_CYC+EN_CYC. The next grant comes one cycle later.
- Back-to-back write spacing is SETUP_CYC+EN_CYC+2 cycles. With defaults this is 5.
- Clear: clr_req sampled at t gives lat_rst=0 and clr_done=1 at t+1, and IDLE at t+2.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- LATCH_SCHED_RR_EN defined: round-robin arbitration.
  - The search starts at (last winner + 1) mod NREQ.
  - The pointer updates on each grant.
- LATCH_SCHED_RR_EN undefined: fixed priority, lowest index wins.
  - No pointer register exists.

## Structure
- The shared package latch_sched_pkg holds:
  - the state enum (IDLE, CLEAR, SETUP, ENABLE, HOLD)
  - default parameter constants
  - a counter-width function
- One sub-module, latch_req_arbiter:
  - combinational one-hot pick from req
  - the round-robin pointer register when LATCH_SCHED_RR_EN is defined
- The top level holds the FSM, the counter and the latch-pin registers.

## Test plan
- Single write, defaults: req=4'b0010, wdata[15:8]=8'hA5 at t.
  - Required: gnt=4'b0010 at t+1, lat_d=8'hA5 at t+1, lat_en high at t+2..t+3, done[1] pulses at t+4, IDLE at t+5.
- Contention with RR, req=4'b1111 held:
  - Required grant order is 0,1,2,3,0, with 5-cycle spacing.
  - Without the macro, every grant goes to index 0.
- Clear priority: clr_req=1 and req=4'b0001 together at t.
  - Required: lat_rst=0 and clr_done at t+1, then the write grant at t+3.
- Requester abort: req[2] drops during SETUP.
  - Required: lat_en pulse still occurs, done[2] still pulses, and lat_d is unchanged.
- Reset mid-ENABLE: rst=0 while lat_en=1.
  - Required: lat_en=0, lat_rst=0 and gnt=0 immediately.
  - After release: IDLE, lat_d=0, no done pulse.
- Parameter corner: SETUP_CYC=1, EN_CYC=1, NREQ=2.
  - Required: lat_en high for exactly 1 cycle.
  - Counter never wraps; checked by assertion.
